edge_frame_capture: RTL and testbench



---
 rtl/canny_pkg.sv | 19 +
 rtl/frame_ram_sdp.sv | 32 +++
 rtl/edge_frame_capture.sv | 234 +++++++++++++++++++++++
 tb/tb_edge_frame_capture.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/canny_pkg.sv
// Shared definitions for the Canny back end: capture FSM states, default frame
// geometry and a helper for the packed-word count of one frame.
package canny_pkg;

   typedef enum logic [1:0] {
      CAP_IDLE    = 2'd0,
      CAP_CAPTURE = 2'd1,
      CAP_DONE    = 2'd2
   } cap_state_t;

   localparam int DEF_IMG_W  = 256;
   localparam int DEF_IMG_H  = 256;
   localparam int DEF_WORD_W = 32;

   function automatic int words_per_frame(input int img_w, input int img_h, input int word_w);
      return (img_w * img_h) / word_w;
   endfunction

endpackage

// File: rtl/frame_ram_sdp.sv
// Simple dual-port frame RAM: one write port, one enabled registered read port,
// read-before-write on an address collision. Written to infer block RAM.
module frame_ram_sdp #(
   parameter int DEPTH  = 2048,
   parameter int WIDTH  = 32,
   parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_reg;

   // No reset on the array or the read register so the tools can map both into the RAM primitive.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata_reg <= mem[raddr];
      end
   end

   assign rdata = rdata_reg;

endmodule

// File: rtl/edge_frame_capture.sv
// Captures one frame of binary edge pixels, packs them LSB-first into WORD_W-bit words
// and stores them in a frame RAM readable by the host. Stats counters: EDGE_CAPTURE_STATS_EN.
module edge_frame_capture
   import canny_pkg::*;
#(
   parameter int IMG_W  = DEF_IMG_W,
   parameter int IMG_H  = DEF_IMG_H,
   parameter int WORD_W = DEF_WORD_W,
   parameter int ADDR_W = $clog2(IMG_W * IMG_H / WORD_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_pixel,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              frame_done,
   output logic              done,
   output logic              drop_flag
`ifdef EDGE_CAPTURE_STATS_EN
   ,
   output logic [$clog2(IMG_W*IMG_H+1)-1:0] edge_count,
   output logic [15:0]       drop_count
`endif
);

   localparam int NUM_PIX    = IMG_W * IMG_H;
   localparam int NUM_WORDS  = words_per_frame(IMG_W, IMG_H, WORD_W);
   localparam int PIX_CNT_W  = $clog2(NUM_PIX) + 1;
   localparam int BIT_CNT_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [PIX_CNT_W-1:0] LAST_PIX  = PIX_CNT_W'(NUM_PIX - 1);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WORD_W - 1);
   localparam logic [ADDR_W:0]      WORDS_LIM = (ADDR_W + 1)'(NUM_WORDS);

   generate
      if ((IMG_W * IMG_H) % WORD_W != 0) begin : g_bad_geometry
         $error("edge_frame_capture: IMG_W*IMG_H must be a multiple of WORD_W");
      end
   endgenerate

   cap_state_t state_reg, state_next;

   logic                 enter_capture;
   logic                 accept;
   logic                 drop;
   logic                 last_pixel;
   logic                 word_full;
   logic                 pix_bit;

   logic [PIX_CNT_W-1:0] pix_cnt_reg;
   logic [BIT_CNT_W-1:0] bit_cnt_reg;
   logic [WORD_W-1:0]    shift_reg;
   logic [WORD_W-1:0]    shift_next;
   logic [ADDR_W-1:0]    waddr_reg;
   logic                 wr_en_reg;
   logic [WORD_W-1:0]    wr_data_reg;
   logic                 frame_done_reg;
   logic                 done_reg;
   logic                 drop_flag_reg;

   logic                 rd_in_range;
   logic                 rd_valid_reg;
   logic                 rd_hit_reg;
   logic [WORD_W-1:0]    ram_q;

   assign pix_bit = |in_pixel;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= CAP_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      enter_capture = 1'b0;
      accept        = 1'b0;
      drop          = 1'b0;
      last_pixel    = 1'b0;
      word_full     = 1'b0;
      case (state_reg)
         CAP_IDLE, CAP_DONE: begin
            drop = in_valid;
            if (start) begin
               state_next    = CAP_CAPTURE;
               enter_capture = 1'b1;
            end
         end
         CAP_CAPTURE: begin
            // start is deliberately not looked at here, even alongside the final pixel.
            if (in_valid) begin
               accept    = 1'b1;
               word_full = (bit_cnt_reg == LAST_BIT);
               if (pix_cnt_reg == LAST_PIX) begin
                  last_pixel = 1'b1;
                  state_next = CAP_DONE;
               end
            end
         end
         default: state_next = CAP_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- packing
   // Shift right so that after WORD_W pixels the earliest one sits in bit 0.
   genvar gi;
   generate
      for (gi = 0; gi < WORD_W - 1; gi++) begin : g_shift
         assign shift_next[gi] = shift_reg[gi+1];
      end
   endgenerate
   assign shift_next[WORD_W-1] = pix_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_reg    <= '0;
         bit_cnt_reg    <= '0;
         shift_reg      <= '0;
         wr_en_reg      <= 1'b0;
         wr_data_reg    <= '0;
         frame_done_reg <= 1'b0;
         done_reg       <= 1'b0;
         drop_flag_reg  <= 1'b0;
      end else begin
         frame_done_reg <= 1'b0;
         wr_en_reg      <= 1'b0;
         if (enter_capture) begin
            pix_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            drop_flag_reg <= 1'b0;
            done_reg      <= 1'b0;
         end else if (accept) begin
            pix_cnt_reg <= pix_cnt_reg + PIX_CNT_W'(1);
            bit_cnt_reg <= word_full ? '0 : bit_cnt_reg + BIT_CNT_W'(1);
            shift_reg   <= shift_next;
            if (word_full) begin
               wr_en_reg   <= 1'b1;
               wr_data_reg <= shift_next;
            end
            if (last_pixel) begin
               frame_done_reg <= 1'b1;
               done_reg       <= 1'b1;
            end
         end else if (drop) begin
            drop_flag_reg <= 1'b1;
         end
      end
   end

   // The pending word still lands at the old address if a new capture starts on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waddr_reg <= '0;
      end else if (enter_capture) begin
         waddr_reg <= '0;
      end else if (wr_en_reg) begin
         waddr_reg <= waddr_reg + ADDR_W'(1);
      end
   end

   // ---------------------------------------------------------------- RAM + host port
   assign rd_in_range = ({1'b0, rd_addr} < WORDS_LIM);

   frame_ram_sdp #(
      .DEPTH  (NUM_WORDS),
      .WIDTH  (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_en_reg),
      .waddr (waddr_reg),
      .wdata (wr_data_reg),
      .re    (rd_en && rd_in_range),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

   // rd_hit_reg masks the unreset RAM output until a valid in-range read has loaded it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
         rd_hit_reg   <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         if (rd_en) begin
            rd_hit_reg <= rd_in_range;
         end
      end
   end

   assign rd_data    = rd_hit_reg ? ram_q : '0;
   assign rd_valid   = rd_valid_reg;
   assign busy       = (state_reg == CAP_CAPTURE);
   assign frame_done = frame_done_reg;
   assign done       = done_reg;
   assign drop_flag  = drop_flag_reg;

`ifdef EDGE_CAPTURE_STATS_EN
   localparam int EDGE_CNT_W = $clog2(NUM_PIX + 1);

   logic [EDGE_CNT_W-1:0] edge_cnt_reg;
   logic [15:0]           drop_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt_reg <= '0;
         drop_cnt_reg <= '0;
      end else begin
         if (enter_capture) begin
            edge_cnt_reg <= '0;
         end else if (accept && pix_bit) begin
            edge_cnt_reg <= edge_cnt_reg + EDGE_CNT_W'(1);
         end
         if (enter_capture) begin
            drop_cnt_reg <= '0;
         end else if (drop && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
         end
      end
   end

   assign edge_count = edge_cnt_reg;
   assign drop_count = drop_cnt_reg;
`endif

endmodule

// File: tb/tb_edge_frame_capture.sv
// Directed bench for edge_frame_capture on a 64x2 frame packed into four 32-bit words.
module tb_edge_frame_capture;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic [7:0]  in_pixel;
   logic        rd_en;
   logic [1:0]  rd_addr;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        frame_done;
   logic        done;
   logic        drop_flag;
`ifdef EDGE_CAPTURE_STATS_EN
   logic [7:0]  edge_count;
   logic [15:0] drop_count;
`endif

   int vectors    = 0;
   int miscompares = 0;
   int fd_pulses  = 0;

   edge_frame_capture #(
      .IMG_W  (64),
      .IMG_H  (2),
      .WORD_W (32)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .in_valid   (in_valid),
      .in_pixel   (in_pixel),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .busy       (busy),
      .frame_done (frame_done),
      .done       (done),
      .drop_flag  (drop_flag)
`ifdef EDGE_CAPTURE_STATS_EN
      ,
      .edge_count (edge_count),
      .drop_count (drop_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) fd_pulses++;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish, got no summary, required completion");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_word(input logic [1:0] a);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en   = 1'b0;
      $display("read addr=%0d data=%h valid=%b", a, rd_data, rd_valid);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pixel = 8'h00; rd_en = 1'b0; rd_addr = 2'd0;
      tick(); tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b need 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b need 0", done); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL reset_frame_done got %b need 0", frame_done); end
      vectors++; if (drop_flag !== 1'b0) begin miscompares++; $display("FAIL reset_drop_flag got %b need 0", drop_flag); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rd_valid got %b need 0", rd_valid); end
      vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL reset_rd_data got %h need 0", rd_data); end
      rst_n = 1'b1;
      tick();
      $display("reset applied and released");
   endtask

   task automatic test_full_frame();
      fd_pulses = 0;
      start = 1'b1; tick(); start = 1'b0;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL full_busy got %b need 1", busy); end
      for (int k = 0; k < 128; k++) begin
         in_valid = 1'b1;
         in_pixel = (k % 2 == 1) ? 8'hFF : 8'h00;
         tick();
         if (k >= 126) begin
            vectors++;
            if (frame_done !== (k == 127)) begin
               miscompares++; $display("FAIL full_frame_done_k%0d got %b need %b", k, frame_done, (k == 127));
            end
         end
      end
      in_valid = 1'b0;
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL full_done got %b need 1", done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL full_busy_after got %b need 0", busy); end
      tick(); tick();
      vectors++; if (fd_pulses !== 1) begin miscompares++; $display("FAIL full_fd_pulses got %0d need 1", fd_pulses); end
      $display("frame alt captured");
      for (int w = 0; w < 4; w++) begin
         read_word(2'(w));
         vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL full_rd_valid_w%0d got %b need 1", w, rd_valid); end
         vectors++; if (rd_data !== 32'hAAAAAAAA) begin miscompares++; $display("FAIL full_word%0d got %h need aaaaaaaa", w, rd_data); end
         tick();
         vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL full_rd_valid_drop_w%0d got %b need 0", w, rd_valid); end
      end
   endtask

   task automatic test_sparse();
      logic [31:0] exp_w [4];
      exp_w[0] = 32'h00000001; exp_w[1] = 32'h0; exp_w[2] = 32'h0; exp_w[3] = 32'h80000000;
      fd_pulses = 0;
      start = 1'b1; tick(); start = 1'b0;
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL sparse_done_cleared got %b need 0", done); end
      for (int k = 0; k < 128; k++) begin
         in_valid = 1'b1;
         in_pixel = (k == 0 || k == 127) ? 8'hFF : 8'h00;
         tick();
         if (k != 127) begin
            in_valid = 1'b0;
            in_pixel = 8'hFF;   // junk while in_valid is low
            tick();
         end
      end
      in_valid = 1'b0;
      in_pixel = 8'h00;
      vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL sparse_frame_done got %b need 1", frame_done); end
      // read of word 3 while it is being written returns the previous frame's word
      read_word(2'd3);
      vectors++; if (rd_data !== 32'hAAAAAAAA) begin miscompares++; $display("FAIL sparse_rbw got %h need aaaaaaaa", rd_data); end
      vectors++; if (frame_done !== 1'b0) begin miscompares++; $display("FAIL sparse_fd_fall got %b need 0", frame_done); end
      vectors++; if (fd_pulses !== 1) begin miscompares++; $display("FAIL sparse_fd_pulses got %0d need 1", fd_pulses); end
      for (int w = 0; w < 4; w++) begin
         read_word(2'(w));
         vectors++; if (rd_data !== exp_w[w]) begin miscompares++; $display("FAIL sparse_word%0d got %h need %h", w, rd_data, exp_w[w]); end
      end
   endtask

   task automatic test_drop();
      vectors++; if (drop_flag !== 1'b0) begin miscompares++; $display("FAIL drop_pre got %b need 0", drop_flag); end
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_pixel = 8'hFF; tick();
      end
      in_valid = 1'b0;
      vectors++; if (drop_flag !== 1'b1) begin miscompares++; $display("FAIL drop_flag_set got %b need 1", drop_flag); end
`ifdef EDGE_CAPTURE_STATS_EN
      vectors++; if (drop_count !== 16'd5) begin miscompares++; $display("FAIL drop_count got %0d need 5", drop_count); end
`endif
      start = 1'b1; tick(); start = 1'b0;
      vectors++; if (drop_flag !== 1'b0) begin miscompares++; $display("FAIL drop_flag_clear got %b need 0", drop_flag); end
`ifdef EDGE_CAPTURE_STATS_EN
      vectors++; if (drop_count !== 16'd0) begin miscompares++; $display("FAIL drop_count_clear got %0d need 0", drop_count); end
`endif
      for (int k = 0; k < 128; k++) begin
         in_valid = 1'b1;
         in_pixel = (k >= 32 && k < 80) ? 8'h01 : 8'h00;
         tick();
      end
      in_valid = 1'b0;
      tick();
      $display("frame after drops captured");
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [4];
      logic [1:0]  order [4];
      exp_w[0] = 32'h0; exp_w[1] = 32'hFFFFFFFF; exp_w[2] = 32'h0000FFFF; exp_w[3] = 32'h0;
      order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd3; order[3] = 2'd2;
      rd_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_addr = order[i];
         tick();
         $display("read addr=%0d data=%h valid=%b", order[i], rd_data, rd_valid);
         vectors++; if (rd_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_%0d got %b need 1", i, rd_valid); end
         vectors++; if (rd_data !== exp_w[order[i]]) begin miscompares++; $display("FAIL b2b_word%0d got %h need %h", order[i], rd_data, exp_w[order[i]]); end
      end
      rd_en = 1'b0;
      rd_addr = 2'd1;
      tick();
      vectors++; if (rd_data !== 32'h0000FFFF) begin miscompares++; $display("FAIL b2b_hold got %h need 0000ffff", rd_data); end
      vectors++; if (rd_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_valid_off got %b need 0", rd_valid); end
   endtask

   task automatic test_reset_mid();
      start = 1'b1; tick(); start = 1'b0;
      fd_pulses = 0;
      for (int k = 0; k < 70; k++) begin
         in_valid = 1'b1; in_pixel = 8'hFF; tick();
      end
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_busy got %b need 0", busy); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done got %b need 0", done); end
      vectors++; if (rd_data !== 32'h0) begin miscompares++; $display("FAIL rstmid_rd_data got %h need 0", rd_data); end
      tick(); tick();
      rst_n = 1'b1;
      tick(); tick();
      vectors++; if (fd_pulses !== 0) begin miscompares++; $display("FAIL rstmid_fd_pulses got %0d need 0", fd_pulses); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstmid_done_after got %b need 0", done); end
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 128; k++) begin
         in_valid = 1'b1;
         in_pixel = (k % 2 == 0) ? 8'h80 : 8'h00;
         tick();
      end
      in_valid = 1'b0;
      vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL rstmid_frame_done got %b need 1", frame_done); end
      tick();
      read_word(2'd0);
      vectors++; if (rd_data !== 32'h55555555) begin miscompares++; $display("FAIL rstmid_word0 got %h need 55555555", rd_data); end
      read_word(2'd3);
      vectors++; if (rd_data !== 32'h55555555) begin miscompares++; $display("FAIL rstmid_word3 got %h need 55555555", rd_data); end
   endtask

   task automatic test_start_last();
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 127; k++) begin
         in_valid = 1'b1; in_pixel = 8'h00; tick();
      end
      in_pixel = 8'hFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b0;
      vectors++; if (frame_done !== 1'b1) begin miscompares++; $display("FAIL sl_frame_done got %b need 1", frame_done); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sl_busy got %b need 0", busy); end
      tick();
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sl_busy_hold got %b need 0", busy); end
      vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL sl_done got %b need 1", done); end
      in_valid = 1'b1; in_pixel = 8'h00; tick(); in_valid = 1'b0;
      vectors++; if (drop_flag !== 1'b1) begin miscompares++; $display("FAIL sl_drop_flag got %b need 1", drop_flag); end
      read_word(2'd3);
      vectors++; if (rd_data !== 32'h80000000) begin miscompares++; $display("FAIL sl_word3 got %h need 80000000", rd_data); end
   endtask

`ifdef EDGE_CAPTURE_STATS_EN
   task automatic test_stats();
      vectors++; if (drop_count !== 16'd1) begin miscompares++; $display("FAIL stats_drop_count got %0d need 1", drop_count); end
      start = 1'b1; tick(); start = 1'b0;
      for (int k = 0; k < 128; k++) begin
         in_valid = 1'b1; in_pixel = 8'hFF; tick();
      end
      in_valid = 1'b0;
      vectors++; if (edge_count !== 8'd128) begin miscompares++; $display("FAIL stats_edge_count got %0d need 128", edge_count); end
      tick();
      vectors++; if (edge_count !== 8'd128) begin miscompares++; $display("FAIL stats_edge_hold got %0d need 128", edge_count); end
      start = 1'b1; tick(); start = 1'b0;
      vectors++; if (edge_count !== 8'd0) begin miscompares++; $display("FAIL stats_edge_clear got %0d need 0", edge_count); end
      $display("stats frame checked");
   endtask
`endif

   initial begin
      test_reset();
      test_full_frame();
      test_sparse();
      test_drop();
      test_back_to_back();
      test_reset_mid();
      test_start_last();
`ifdef EDGE_CAPTURE_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
